// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one 32-bit ALU between two requesters, with issue and response stages.
// Optional statistics counters are enabled by defining ALU_ARB_STATS_EN.
module alu_arbiter #(
    parameter int CNT_W   = 16,
    parameter bit RR_INIT = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [3:0]       req0_op,
    input  logic [31:0]      req0_a,
    input  logic [31:0]      req0_b,
    input  logic [4:0]       req0_shamt,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [3:0]       req1_op,
    input  logic [31:0]      req1_a,
    input  logic [31:0]      req1_b,
    input  logic [4:0]       req1_shamt,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic             resp_id,
    output logic [31:0]      resp_result,
    output logic             resp_negative,
    output logic             resp_zero,
    output logic             resp_carry,
`ifdef ALU_ARB_STATS_EN
    output logic [CNT_W-1:0] grant0_cnt,
    output logic [CNT_W-1:0] grant1_cnt,
    output logic [CNT_W-1:0] stall_cnt,
`endif
    output logic             busy
);

    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic        rr_reg;
    logic        s1_valid_reg;
    logic [3:0]  s1_op_reg;
    logic [31:0] s1_a_reg;
    logic [31:0] s1_b_reg;
    logic [4:0]  s1_shamt_reg;
    logic        s1_id_reg;
    logic        s2_valid_reg;
    logic        s2_id_reg;
    logic [31:0] s2_result_reg;
    logic        s2_negative_reg;
    logic        s2_zero_reg;
    logic        s2_carry_reg;
    logic        s1_adv;
    logic        s2_adv;
    logic        grant_en;
    logic        grant_id;
    logic [32:0] alu_sum;
    logic [31:0] alu_result;
    logic        alu_carry;

    assign req_valid = {req1_valid, req0_valid};
    assign s2_adv    = !s2_valid_reg || resp_ready;
    assign s1_adv    = !s1_valid_reg || s2_adv;

    // With both requesting, rr picks the winner; otherwise the lone requester wins.
    always_comb begin
        grant_id = req_valid[1];
        if (req_valid == 2'b11)
            grant_id = rr_reg;
        grant_en = !rst && s1_adv && (req_valid != 2'b00);
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : gen_ready
            assign req_ready[gi] = grant_en && (grant_id == (gi == 1));
        end
    endgenerate

    assign req0_ready = req_ready[0];
    assign req1_ready = req_ready[1];

    always_comb begin
        alu_sum    = {1'b0, s1_a_reg} + {1'b0, s1_b_reg};
        alu_result = 32'd0;
        alu_carry  = 1'b0;
        case (s1_op_reg)
            4'b0000: begin
                alu_result = alu_sum[31:0];
                alu_carry  = alu_sum[32];
            end
            4'b0001: alu_result = ~s1_a_reg;
            4'b0010: alu_result = s1_a_reg - s1_b_reg;
            4'b0011: alu_result = s1_a_reg & s1_b_reg;
            4'b0100: alu_result = s1_a_reg ^ s1_b_reg;
            4'b0101: alu_result = s1_a_reg << s1_shamt_reg;
            4'b0110: alu_result = s1_a_reg >> s1_shamt_reg;
            4'b0111: alu_result = $signed(s1_a_reg) >>> s1_shamt_reg;
            4'b1000: alu_result = s1_a_reg >> s1_b_reg[4:0];
            4'b1001: alu_result = s1_a_reg << s1_b_reg[4:0];
            4'b1010: alu_result = $signed(s1_a_reg) >>> s1_b_reg[4:0];
            default: alu_result = 32'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_reg          <= RR_INIT;
            s1_valid_reg    <= 1'b0;
            s2_valid_reg    <= 1'b0;
            s2_id_reg       <= 1'b0;
            s2_result_reg   <= 32'd0;
            s2_negative_reg <= 1'b0;
            s2_zero_reg     <= 1'b0;
            s2_carry_reg    <= 1'b0;
        end else begin
            if (grant_en) begin
                s1_valid_reg <= 1'b1;
                s1_id_reg    <= grant_id;
                s1_op_reg    <= grant_id ? req1_op    : req0_op;
                s1_a_reg     <= grant_id ? req1_a     : req0_a;
                s1_b_reg     <= grant_id ? req1_b     : req0_b;
                s1_shamt_reg <= grant_id ? req1_shamt : req0_shamt;
                rr_reg       <= ~grant_id;
            end else if (s1_adv) begin
                s1_valid_reg <= 1'b0;
            end
            // The response register only moves when the consumer can take its contents.
            if (s2_adv) begin
                s2_valid_reg    <= s1_valid_reg;
                s2_id_reg       <= s1_id_reg;
                s2_result_reg   <= alu_result;
                s2_negative_reg <= alu_result[31];
                s2_zero_reg     <= (alu_result == 32'd0);
                s2_carry_reg    <= alu_carry;
            end
        end
    end

    assign resp_valid    = s2_valid_reg;
    assign resp_id       = s2_id_reg;
    assign resp_result   = s2_result_reg;
    assign resp_negative = s2_negative_reg;
    assign resp_zero     = s2_zero_reg;
    assign resp_carry    = s2_carry_reg;
    assign busy          = s1_valid_reg || s2_valid_reg;

`ifdef ALU_ARB_STATS_EN
    logic [CNT_W-1:0] stall_cnt_reg;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : gen_grant_cnt
            logic [CNT_W-1:0] cnt_reg;
            always_ff @(posedge clk) begin
                if (rst)
                    cnt_reg <= '0;
                else if (req_valid[gi] && req_ready[gi] && (cnt_reg != '1))
                    cnt_reg <= cnt_reg + CNT_W'(1);
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst)
            stall_cnt_reg <= '0;
        else if ((req_valid != 2'b00) && !grant_en && (stall_cnt_reg != '1))
            stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
    end

    assign grant0_cnt = gen_grant_cnt[0].cnt_reg;
    assign grant1_cnt = gen_grant_cnt[1].cnt_reg;
    assign stall_cnt  = stall_cnt_reg;
`endif

endmodule
